// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver with mid-bit sampling.
//
// Frame: 1 start bit (0), 8 data bits LSB first, [even parity bit], 1 stop bit (1).
// Optional feature: define UART_RX_PARITY_EN to expect and check an even parity bit
// between the last data bit and the stop bit; without it o_RX_Err flags framing only.
//
// Ports:
//   i_Clock      sole clock, rising edge
//   i_Rst_L      synchronous active-low reset
//   i_RX_Serial  asynchronous serial line, idle high
//   o_RX_DV      one-cycle pulse, o_RX_Byte just updated with a good byte
//   o_RX_Byte    last correctly received byte, held until the next good byte
//   o_RX_Err     one-cycle pulse on a framing (or parity) error
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Err
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         byte_q, byte_d;
    logic               par_err_q, par_err_d;
    logic               dv_q, dv_d;
    logic               err_q, err_d;
    logic               armed_q, armed_d;
    logic               sync1_q, sync2_q;
    logic [1:0]         fill_q;
    logic               rx_s;

    assign rx_s      = sync2_q;
    assign o_RX_DV   = dv_q;
    assign o_RX_Err  = err_q;
    assign o_RX_Byte = byte_q;

    // Two-flop synchronizer; fill_q marks when both flops hold real line samples
    // rather than their reset value.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= i_RX_Serial;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= 8'h00;
            byte_q    <= 8'h00;
            par_err_q <= 1'b0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            par_err_q <= par_err_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
            armed_q   <= armed_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        par_err_d = par_err_q;
        dv_d      = 1'b0;
        err_d     = 1'b0;
        // A line held low through reset must go high once before a start edge counts.
        armed_d   = armed_q | (fill_q[1] & rx_s);

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                idx_d     = '0;
                par_err_d = 1'b0;
                if (armed_q && !rx_s) begin
                    state_d = S_START;
                end
            end

            // Re-check the line at mid start bit to reject glitches.
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // From mid start bit, a full bit period lands at mid data bit.
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_W'(7)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = (^shift_q) ^ rx_s;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                state_d = S_IDLE;
`endif
            end

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s && !par_err_q) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_CLEANUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_CLEANUP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int C = 217;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_EXP = 2 + (C - 1) / 2 + 9 * C + 1 + C;
`else
    localparam int LAT_EXP = 2 + (C - 1) / 2 + 9 * C + 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       dv;
    logic [7:0] rx_byte;
    logic       err;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .i_Clock    (clk),
        .i_Rst_L    (rst_n),
        .i_RX_Serial(rx),
        .o_RX_DV    (dv),
        .o_RX_Byte  (rx_byte),
        .o_RX_Err   (err)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] data;   // byte expected on o_RX_Byte when the pulse appears
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   start_cyc = 0;
    logic lat_armed = 1'b0;
    logic prev_dv   = 1'b0;
    logic prev_err  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses DV or Err.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dv  <= 1'b0;
            prev_err <= 1'b0;
        end else begin
            if (dv || err) begin
                chk("dv_err_exclusive", 32'(dv & err), 32'd0);
                chk("pulse_one_cycle", 32'((dv & prev_dv) | (err & prev_err)), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, dv, err}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_kind_is_err", 32'(err), 32'(e.is_err));
                    chk("rx_byte", 32'(rx_byte), 32'(e.data));
                end
                if (dv && lat_armed) begin
                    int lat;
                    lat = cyc - (start_cyc + 1);
                    n_checks++;
                    if (lat >= LAT_EXP - 1 && lat <= LAT_EXP + 1) n_pass++;
                    else $display("FAIL latency: got %0d cycles, expected %0d +/-1", lat, LAT_EXP);
                    lat_armed <= 1'b0;
                end
            end
            prev_dv  <= dv;
            prev_err <= err;
        end
    end

    task automatic send_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int start_len, input int bit_len,
                              input logic stop, input logic par_flip);
        start_cyc = cyc;
        send_bit(1'b0, start_len);
        for (int i = 0; i < 8; i++) send_bit(d[i], bit_len);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip, bit_len);
`else
        if (par_flip) $display("note: parity flip ignored without parity");
`endif
        send_bit(stop, bit_len);
        rx = 1'b1;
    endtask

    task automatic push(input logic is_err, input logic [7:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    // Bounded wait for all expected pulses to be consumed.
    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 4 * C) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b0;

        // Reset with line low, then no frame until the line goes high and falls.
        repeat (5) @(posedge clk);
        #1;
        chk("reset_dv", 32'(dv), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_byte", 32'(rx_byte), 32'h00);
        rst_n = 1'b1;
        repeat (12 * C) @(posedge clk);
        #1;
        chk("no_frame_while_low_byte", 32'(rx_byte), 32'h00);
        send_bit(1'b1, 2 * C);

        // Nominal 0x37 with latency check.
        push(1'b0, 8'h37);
        lat_armed = 1'b1;
        send_frame(8'h37, C, C, 1'b1, 1'b0);
        send_bit(1'b1, C);
        drain("drain_nominal");
        send_bit(1'b1, 3 * C);
        chk("byte_held_37", 32'(rx_byte), 32'h37);

        // Stretched start bit and fast data bits.
        push(1'b0, 8'h37);
        send_frame(8'h37, 240, 215, 1'b1, 1'b0);
        send_bit(1'b1, C);
        drain("drain_skew");

        // Glitch rejection, then a good frame proves the FSM recovered.
        send_bit(1'b0, 50);
        send_bit(1'b1, 2 * C);
        chk("glitch_no_pulse", 32'(exp_q.size()), 32'd0);
        push(1'b0, 8'hC3);
        send_frame(8'hC3, C, C, 1'b1, 1'b0);
        send_bit(1'b1, C);
        drain("drain_after_glitch");

        // Framing error: stop bit low, byte held.
        push(1'b1, 8'hC3);
        send_frame(8'h55, C, C, 1'b0, 1'b0);
        send_bit(1'b1, 2 * C);
        drain("drain_framing");
        chk("byte_held_after_framing", 32'(rx_byte), 32'hC3);

`ifdef UART_RX_PARITY_EN
        // 0x55 has even ones count, so a parity bit of 1 is wrong.
        push(1'b1, 8'hC3);
        send_frame(8'h55, C, C, 1'b1, 1'b1);
        send_bit(1'b1, 2 * C);
        drain("drain_parity");
        chk("byte_held_after_parity", 32'(rx_byte), 32'hC3);
`endif

        // Back-to-back frames with no idle gap.
        push(1'b0, 8'hA5);
        push(1'b0, 8'h3C);
        send_frame(8'hA5, C, C, 1'b1, 1'b0);
        send_frame(8'h3C, C, C, 1'b1, 1'b0);
        send_bit(1'b1, C);
        drain("drain_back_to_back");
        chk("byte_after_b2b", 32'(rx_byte), 32'h3C);

        // Reset mid-frame abandons it silently and clears the byte.
        send_bit(1'b0, C);
        send_bit(1'b1, C);
        send_bit(1'b0, C);
        rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_bit(1'b1, 12 * C);
        chk("byte_after_midframe_reset", 32'(rx_byte), 32'h00);
        chk("midframe_reset_no_pulse", 32'(exp_q.size()), 32'd0);

        push(1'b0, 8'h81);
        send_frame(8'h81, C, C, 1'b1, 1'b0);
        send_bit(1'b1, C);
        drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, clock cycles per serial bit (25 MHz / 115200 baud); legal range 4..65535.
REQ-002 i_Clock  input  1  sole clock; all logic on rising edge.
REQ-003 i_Rst_L  input  1  reset, synchronous, active-low.
REQ-004 i_RX_Serial  input  1  asynchronous serial line, idle high.
REQ-005 o_RX_DV  output  1  one-cycle pulse, new byte valid.
REQ-006 o_RX_Byte  output  8  last correctly received byte, held until next good byte.
REQ-007 o_RX_Err  output  1  one-cycle pulse on framing or parity error.

Function
REQ-008 i_RX_Serial SHALL pass through a 2-flop synchronizer (reset value 1) before use; all timing below refers to the synchronized line.
REQ-009 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-020), 1 stop bit (1).
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, CLEANUP, plus a bit counter 0..CLKS_PER_BIT-1 and a bit index 0..7.
REQ-011 IDLE: line low -> START with counter cleared; otherwise stay in IDLE.
REQ-012 START: at counter == (CLKS_PER_BIT-1)/2 (integer division), line still low -> DATA with counter cleared; line high -> IDLE (glitch rejected, no outputs).
REQ-013 DATA: at counter == CLKS_PER_BIT-1, sample the line into shift bit[index] and clear counter; after index 7 -> PARITY if enabled, else STOP.
REQ-014 STOP: at counter == CLKS_PER_BIT-1, sample; 1 with no parity error -> load o_RX_Byte, pulse o_RX_DV for exactly one cycle; otherwise pulse o_RX_Err for one cycle, o_RX_Byte unchanged; then -> CLEANUP.
REQ-015 CLEANUP SHALL last one cycle and return to IDLE; a new start edge is accepted from the following cycle.
REQ-016 o_RX_DV and o_RX_Err SHALL never be asserted together and SHALL never be asserted for more than one consecutive cycle.
REQ-017 The receiver SHALL decode correctly with a transmitter bit period within +/-4 percent of CLKS_PER_BIT and a stretched start bit of up to 1.15 bit periods (mid-bit sampling).
REQ-018 Reception latency: o_RX_DV SHALL assert 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the falling start edge on i_RX_Serial (plus one CLKS_PER_BIT if parity is enabled).

Reset
REQ-019 While i_Rst_L is low at a rising clock edge: state IDLE, counters 0, shift register 0x00, o_RX_Byte 0x00, o_RX_DV 0, o_RX_Err 0, synchronizer flops 1; reset mid-frame SHALL abandon the frame with no DV or Err pulse.

Configuration
REQ-020 Macro UART_RX_PARITY_EN: when defined, PARITY state samples a parity bit at counter == CLKS_PER_BIT-1 and flags an error at STOP if (XOR of data bits XOR parity bit) != 0 (even parity); when undefined, the PARITY state is never entered, there is no parity bit in the frame, and o_RX_Err reflects framing errors only.

Verification
REQ-021 Reset: hold i_Rst_L low 5 cycles with line low -> o_RX_DV=0, o_RX_Err=0, o_RX_Byte=0x00, no frame accepted after release until line returns high then falls.
REQ-022 CLKS_PER_BIT=217, 40 ns clock, send 0x37 at 217 clk/bit -> single o_RX_DV pulse, o_RX_Byte=0x37 held afterward.
REQ-023 Skew: start bit 240 clocks, data/stop bits 215 clocks each, byte 0x37 -> o_RX_Byte=0x37, one DV pulse, no Err.
REQ-024 Glitch: line low for 50 clocks then high -> no DV, no Err, FSM back in IDLE.
REQ-025 Framing: send 0x55 with stop bit 0 -> one o_RX_Err pulse, no DV, o_RX_Byte keeps previous value; with UART_RX_PARITY_EN, 0x55 sent with parity bit 1 -> one Err pulse.
REQ-026 Back-to-back 0xA5 then 0x3C with no idle gap -> two DV pulses, bytes 0xA5 then 0x3C.
